// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for the processor data port. Serves one word-addressed
// 32-bit read or write at a time, with a programmable number of wait states
// between accept and a one-cycle ack pulse.
//
// Ports
//   clk    in   1   clock, all state changes on the rising edge
//   rst    in   1   asynchronous, active-high reset
//   req    in   1   access request, sampled only while idle
//   we     in   1   1 = write, 0 = read, sampled with req
//   addr   in   32  word address, sampled with req
//   wdata  in   32  write data, sampled with req
//   rdata  out  32  read data, valid only while ack = 1 (0 for writes/errors)
//   ack    out  1   one-cycle completion pulse
//   busy   out  1   high from the cycle after accept through the ack cycle
//   err    out  1   qualifies ack: address out of range
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W   = 4;
  localparam bit          NO_WAIT = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    NO_WAIT ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_ack;
  logic                  r_busy;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_go_resp;
  logic                  w_cur_we;
  logic [31:0]           w_cur_addr;
  logic [31:0]           w_cur_wdata;
  logic                  w_cur_in_range;
  logic [DEPTH_LOG2-1:0] w_cur_idx;
  logic                  w_mem_wr;

  // With zero wait states RESP is entered on the accepting edge itself, so the
  // access is taken from the live inputs; otherwise from the latched copy.
  assign w_cur_we       = (r_state == S_IDLE) ? we    : r_we;
  assign w_cur_addr     = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_cur_wdata    = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_cur_in_range = ((w_cur_addr >> DEPTH_LOG2) == 32'd0);
  assign w_cur_idx      = w_cur_addr[DEPTH_LOG2-1:0];

  assign w_go_resp = ((r_state == S_WAIT) && (r_cnt == '0)) ||
                     ((r_state == S_IDLE) && req && NO_WAIT);

  // Commit on the edge entering RESP; held off while reset is asserted.
  assign w_mem_wr = w_go_resp && w_cur_we && w_cur_in_range && !rst;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[w_cur_idx] <= w_cur_wdata;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_state <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Response registers load on the edge entering RESP.
      if (w_go_resp) begin
        r_ack   <= 1'b1;
        r_err   <= !w_cur_in_range;
        r_rdata <= (!w_cur_we && w_cur_in_range) ? r_mem[w_cur_idx] : 32'd0;
      end
    end
  end

  assign rdata = r_rdata;
  assign ack   = r_ack;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Self-checking bench for data_mem_responder: one instance with two wait
// states (main target) and one with zero wait states. Expected data comes from
// an associative-array memory model; expected timing from the wait-state count.
module tb_data_mem_responder;

  localparam int unsigned WS = 2;

  logic        clk;
  logic        rst;

  logic        req2, we2, ack2, busy2, err2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        req0, we0, ack0, busy0, err0;
  logic [31:0] addr0, wdata0, rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [int unsigned];

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(WS)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ack(ack2), .busy(busy2), .err(err2)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a < 32'd1024);
  endfunction

  // Start at #1 after a rising edge with the WS=2 instance idle; return at #1
  // after the edge that ends the ack cycle.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat,
                        output int busy_bad);
    rd = '0; e = 1'b0; lat = -1; busy_bad = 0;
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    @(posedge clk); #1;
    // Garbage after accept must not affect the access in flight.
    req2 = 1'b0; we2 = 1'($urandom); addr2 = $urandom; wdata2 = $urandom;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy2) busy_bad++;
      if (ack2) begin
        lat = k; rd = rdata2; e = err2;
        break;
      end
      if (err2) busy_bad++;
    end
    @(posedge clk); #1;
  endtask

  // Access plus full check against the model.
  task automatic do_acc(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] rd, exp_rd;
    logic        e;
    int          lat, bb;
    exp_rd = (!w && in_range(a)) ? model_mem[a] : 32'd0;
    access(w, a, d, rd, e, lat, bb);
    chk($sformatf("%s_lat", tag), 32'(lat), 32'(WS));
    chk($sformatf("%s_err", tag), 32'(e), 32'(!in_range(a)));
    chk($sformatf("%s_rdata", tag), rd, exp_rd);
    chk($sformatf("%s_busy", tag), 32'(bb), 32'd0);
    if (w && in_range(a)) model_mem[a] = d;
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] rd, a, d;
    logic        e, w;
    int          lat, bb, n_ack, last, cnt;
    logic        prev_busy;
    logic [31:0] exp_q[$];

    rst = 1'b1;
    req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;

    // Reset state
    #12;
    chk("rst_ack",   32'(ack2),  32'd0);
    chk("rst_busy",  32'(busy2), 32'd0);
    chk("rst_err",   32'(err2),  32'd0);
    chk("rst_rdata", rdata2,     32'd0);
    chk("rst0_busy", 32'(busy0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table (WS=2)
    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0400, 32'h1111_1111, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_03FF, 32'h0BAD_F00D, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_03FF, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0005, 32'h0,         32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0007, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0000_0007, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0005, 32'h0000_0001, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 32'h0000_0005, 32'h0,         32'h0000_0001, 1'b0};
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e, lat, bb);
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(WS));
      chk($sformatf("vec%0d_err", i),   32'(e),   32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rdata", i), rd,       vecs[i].exp_rdata);
      chk($sformatf("vec%0d_busy", i),  32'(bb),  32'd0);
      if (vecs[i].we && !vecs[i].exp_err) model_mem[vecs[i].addr] = vecs[i].wdata;
    end

    // Randomized accesses against the model
    for (int i = 0; i < 16; i++) do_acc($sformatf("init%0d", i), 1'b1, 32'(i), $urandom);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      d = $urandom;
      if ($urandom_range(0, 7) == 0)
        a = (32'($urandom_range(1, 32'h003F_FFFF)) << 10) | 32'($urandom_range(0, 1023));
      else
        a = 32'($urandom_range(0, 15));
      do_acc($sformatf("rnd%0d", i), w, a, d);
    end

    // Held req, alternating addr changed mid-WAIT: one ack every WS+2 cycles
    do_acc("pre1", 1'b1, 32'd1, 32'h1111_0001);
    do_acc("pre2", 1'b1, 32'd2, 32'h2222_0002);
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'd1; prev_busy = 1'b0;
    n_ack = 0; last = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (busy2 && !prev_busy) begin
        exp_q.push_back(model_mem[addr2]);
        addr2 = (addr2 == 32'd1) ? 32'd2 : 32'd1;
      end
      prev_busy = busy2;
      @(negedge clk);
      if (ack2) begin
        if (exp_q.size() == 0) chk("hold_q_empty", 32'd1, 32'd0);
        else chk($sformatf("hold_rdata%0d", n_ack), rdata2, exp_q.pop_front());
        if (last >= 0) chk($sformatf("hold_gap%0d", n_ack), 32'(c - last), 32'(WS + 2));
        last = c;
        n_ack++;
      end
    end
    req2 = 1'b0;
    chk("hold_acks", 32'(n_ack), 32'd4);
    @(posedge clk); #1;

    // Reset during WAIT of a write: abandoned, not committed
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'd7; wdata2 = 32'h1234_5678;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_ack",   32'(ack2),  32'd0);
    chk("mrst_busy",  32'(busy2), 32'd0);
    chk("mrst_rdata", rdata2,     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ack2) cnt++;
    end
    chk("mrst_no_ack", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    do_acc("mrst_read7", 1'b0, 32'd7, 32'h0);

    // req pulsed in the ack cycle is ignored
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'd5;
    @(posedge clk); #1;
    req2 = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack2) begin lat = k; break; end
    end
    chk("ackpulse_lat", 32'(lat), 32'(WS));
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'd9; wdata2 = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    req2 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ack2 || busy2) cnt++;
    end
    chk("ackpulse_ignored", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    // Pulse in the cycle right after ack is accepted
    do_acc("next_a", 1'b0, 32'd5, 32'h0);
    do_acc("next_b", 1'b0, 32'd9, 32'h0);

    // Zero wait states instance
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h0000_0003;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("ws0_wr_ack", 32'(ack0), 32'd1);
    chk("ws0_wr_err", 32'(err0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    @(posedge clk); #1;
    req0 = 1'b0; addr0 = 32'd0;
    @(negedge clk);
    chk("ws0_rd_ack",   32'(ack0),  32'd1);
    chk("ws0_rd_rdata", rdata0,     32'h0000_0003);
    chk("ws0_rd_busy1", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("ws0_rd_busy2", 32'(busy0), 32'd0);
    chk("ws0_rd_ack2",  32'(ack0),  32'd0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0400;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("ws0_oor_err",   32'(err0), 32'd1);
    chk("ws0_oor_rdata", rdata0,    32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
